// File: rtl/sram_bridge.sv
// sram_bridge: serialises the CPU fetch (rom_*) and load/store (ram_*) ports
// onto one single-port memory bus with an ack handshake. Data is served
// before fetch. stallreq_o holds the CPU until both accesses complete. A
// per-access watchdog force-completes an access on a hung slave.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rom_ce_i/addr_i   fetch request / address;   rom_data_o fetched word
//   ram_ce_i/we_i/sel_i/addr_i/data_i  data access; ram_data_o load word
//   stallreq_o        combinational stall request to ctrl
//   mem_*_o           registered bus request, we, byte enables, addr, wdata
//   mem_rdata_i/ack_i bus read data and completion
//   bus_err_o         one-cycle pulse on watchdog timeout
module sram_bridge #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_INST = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rom_q, rom_d;
  logic [31:0]       ram_q, ram_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic timeout_c, finish_c;
  logic enter_data_c, enter_inst_c, enter_done_c;

  // Byte offset is dropped: the bus only ever sees word-aligned addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rom_addr_i[1:0], ram_addr_i[1:0]};

  // Timeout fires on the WAIT_MAX-th request cycle without ack; ack wins a tie.
  assign timeout_c = req_q && !mem_ack_i && (cnt_q == CNT_W'(WAIT_MAX - 1));
  assign finish_c  = req_q && (mem_ack_i || timeout_c);

  assign stallreq_o = !rst && (state_q != S_DONE) && (rom_ce_i || ram_ce_i);

  // Next-state and registered-output logic; bus fields load on state entry.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rom_d        = rom_q;
    ram_d        = ram_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    enter_data_c = 1'b0;
    enter_inst_c = 1'b0;
    enter_done_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ram_ce_i)      enter_data_c = 1'b1;
        else if (rom_ce_i) enter_inst_c = 1'b1;
      end
      S_DATA: begin
        if (finish_c) begin
          ram_d = (mem_ack_i && !we_q) ? mem_rdata_i : 32'd0;
          err_d = !mem_ack_i;
          if (rom_ce_i) enter_inst_c = 1'b1;
          else          enter_done_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INST: begin
        if (finish_c) begin
          rom_d        = mem_ack_i ? mem_rdata_i : 32'd0;
          err_d        = !mem_ack_i;
          enter_done_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_data_c) begin
      state_d = S_DATA;
      req_d   = 1'b1;
      we_d    = ram_we_i;
      sel_d   = ram_sel_i;
      addr_d  = {ram_addr_i[31:2], 2'b00};
      wdata_d = ram_data_i;
      cnt_d   = '0;
    end
    // req stays high across DATA->INST; only the access fields change.
    if (enter_inst_c) begin
      state_d = S_INST;
      req_d   = 1'b1;
      we_d    = 1'b0;
      sel_d   = 4'hF;
      addr_d  = {rom_addr_i[31:2], 2'b00};
      cnt_d   = '0;
    end
    if (enter_done_c) begin
      state_d = S_DONE;
      req_d   = 1'b0;
      we_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rom_q   <= 32'd0;
      ram_q   <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rom_q   <= rom_d;
      ram_q   <= ram_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_sel_o   = sel_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign bus_err_o   = err_q;
  assign rom_data_o  = rom_q;
  assign ram_data_o  = ram_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: directed cases plus random transactions, checked
// against a cycle-count / latch model derived from the access rules.
module tb_sram_bridge;
  localparam int unsigned WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        bus_err_o;

  sram_bridge #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
    .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
    .stallreq_o(stallreq_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_rom = 32'd0;
  logic [31:0] exp_ram = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycles one access holds the bus: ack after w wait cycles, or the watchdog limit.
  function automatic int acc_cycles(input int w);
    return (w < int'(WAIT_MAX)) ? w + 1 : int'(WAIT_MAX);
  endfunction

  // One CPU cycle's worth of requests, called at a negedge while the DUT is idle.
  // wd/wi: wait cycles before the slave acks (>= WAIT_MAX means never).
  task automatic txn(input bit rce, input bit rwe, input logic [3:0] rsel,
                     input logic [31:0] raddr, input logic [31:0] rwd,
                     input bit ice, input logic [31:0] iaddr,
                     input int wd, input int wi,
                     input logic [31:0] rdd, input logic [31:0] rdi,
                     input bit b2b, input logic [31:0] nxt_addr);
    int          waits [2];
    logic [31:0] rd [2];
    bit          is_data [2];
    int          n_acc, ai, c, stall_cnt, err_cnt, exp_stall, exp_err;
    bit          done;
    n_acc = 0; ai = 0; c = 0; stall_cnt = 0; err_cnt = 0; done = 1'b0;
    if (rce) begin waits[n_acc] = wd; rd[n_acc] = rdd; is_data[n_acc] = 1'b1; n_acc++; end
    if (ice) begin waits[n_acc] = wi; rd[n_acc] = rdi; is_data[n_acc] = 1'b0; n_acc++; end
    exp_stall = 1;
    exp_err   = 0;
    for (int i = 0; i < n_acc; i++) begin
      exp_stall += acc_cycles(waits[i]);
      if (waits[i] >= int'(WAIT_MAX)) exp_err++;
    end
    if (rce) exp_ram = (rwe || wd >= int'(WAIT_MAX)) ? 32'd0 : rdd;
    if (ice) exp_rom = (wi >= int'(WAIT_MAX)) ? 32'd0 : rdi;

    ram_ce_i = rce; ram_we_i = rwe; ram_sel_i = rsel; ram_addr_i = raddr; ram_data_i = rwd;
    rom_ce_i = ice; rom_addr_i = iaddr; mem_ack_i = 1'b0;

    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (bus_err_o) err_cnt++;
      if (!stallreq_o) begin
        done = 1'b1;
      end else begin
        stall_cnt++;
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (mem_req_o) begin
          if (ai < n_acc) begin
            c++;
            if (c == 1) begin
              if (is_data[ai]) begin
                chk("data_addr", mem_addr_o, {raddr[31:2], 2'b00});
                chk("data_we", 32'(mem_we_o), 32'(rwe));
                chk("data_sel", 32'(mem_sel_o), 32'(rsel));
                chk("data_wdata", mem_wdata_o, rwd);
              end else begin
                chk("inst_addr", mem_addr_o, {iaddr[31:2], 2'b00});
                chk("inst_we", 32'(mem_we_o), 32'd0);
                chk("inst_sel", 32'(mem_sel_o), 32'hF);
              end
            end
            if (c == waits[ai] + 1) begin
              mem_ack_i   = 1'b1;
              mem_rdata_i = rd[ai];
            end
            if (c == waits[ai] + 1 || c == int'(WAIT_MAX)) begin
              ai++;
              c = 0;
            end
          end else begin
            chk("extra_access", 32'(ai + 1), 32'(n_acc));
          end
        end
        @(negedge clk);
      end
    end

    chk("reached_done", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    chk("accesses", 32'(ai), 32'(n_acc));
    chk("bus_err_pulses", 32'(err_cnt), 32'(exp_err));
    chk("done_req", 32'(mem_req_o), 32'd0);
    chk("rom_data", rom_data_o, exp_rom);
    chk("ram_data", ram_data_o, exp_ram);

    // Ack during DONE must be ignored; a request raised in DONE waits for IDLE.
    mem_ack_i   = 1'b1;
    mem_rdata_i = $urandom;
    ram_ce_i    = 1'b0;
    rom_ce_i    = b2b;
    rom_addr_i  = nxt_addr;
    @(negedge clk);
    #1;
    mem_ack_i = 1'b0;
    chk("done_ack_rom", rom_data_o, exp_rom);
    chk("done_ack_ram", ram_data_o, exp_ram);
    chk("idle_req", 32'(mem_req_o), 32'd0);
    chk("idle_err", 32'(bus_err_o), 32'd0);
    chk("idle_stall", 32'(stallreq_o), 32'(b2b));
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(7, 0));
    if (r < 6)  return int'($urandom_range(3, 0));
    if (r == 6) return int'(WAIT_MAX) - 1;
    return int'(WAIT_MAX) + int'($urandom_range(4, 0));
  endfunction

  initial begin
    logic [31:0] nxt;
    bit          rce, ice;
    rst = 1'b1;
    rom_ce_i = 1'b0; rom_addr_i = 32'd0; ram_ce_i = 1'b0; ram_we_i = 1'b0;
    ram_sel_i = 4'd0; ram_addr_i = 32'd0; ram_data_i = 32'd0;
    mem_rdata_i = 32'd0; mem_ack_i = 1'b0;

    // Reset state, with requests present so the stall gating is visible.
    #2;
    rom_ce_i = 1'b1; ram_ce_i = 1'b1;
    #1;
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    chk("rst_sel", 32'(mem_sel_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rom", rom_data_o, 32'd0);
    chk("rst_ram", ram_data_o, 32'd0);
    @(negedge clk);
    rom_ce_i = 1'b0; ram_ce_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_no_req", 32'(mem_req_o), 32'd0);
    chk("idle_no_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);

    // Fetch only, zero-wait slave.
    txn(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0004, 0, 0,
        32'd0, 32'h3C01_1234, 1'b0, 32'd0);
    // Load plus fetch, two wait cycles each; unaligned data address.
    txn(1'b1, 1'b0, 4'b1000, 32'h0000_0103, $urandom, 1'b1, 32'h0000_0010, 2, 2,
        32'hAABB_CCDD, 32'h2402_0001, 1'b0, 32'd0);
    // Store only: DATA straight to DONE, load latch cleared.
    txn(1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'h0000_BEEF, 1'b0, 32'd0, 0, 0,
        $urandom, 32'd0, 1'b0, 32'd0);
    // Watchdog: fetch never acked.
    txn(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0080, 0, 100,
        32'd0, 32'h1234_5678, 1'b0, 32'd0);
    // Ack on the last allowed cycle wins over the timeout.
    txn(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0084, 0, int'(WAIT_MAX) - 1,
        32'd0, 32'hCAFE_F00D, 1'b0, 32'd0);
    // Timed-out load followed by a normal fetch.
    txn(1'b1, 1'b0, 4'hF, 32'h0000_0200, $urandom, 1'b1, 32'h0000_0088, 100, 1,
        32'h5555_AAAA, 32'h0BAD_BEEF, 1'b0, 32'd0);
    // Back-to-back: a new fetch raised during DONE is issued from IDLE.
    nxt = 32'h0000_0106;
    txn(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0100, 0, 0,
        32'd0, 32'h1111_2222, 1'b1, nxt);
    txn(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, nxt, 0, 1,
        32'd0, 32'h3333_4444, 1'b0, 32'd0);
    // Data latch non-zero before the reset test.
    txn(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'd0, 1'b0, 32'd0, 1, 0,
        32'h7777_8888, 32'd0, 1'b0, 32'd0);

    // Asynchronous reset in the middle of a fetch.
    @(negedge clk);
    rom_ce_i = 1'b1; rom_addr_i = 32'h0000_0400; ram_ce_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(mem_req_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req_o), 32'd0);
    chk("midrst_stall", 32'(stallreq_o), 32'd0);
    chk("midrst_err", 32'(bus_err_o), 32'd0);
    chk("midrst_rom", rom_data_o, 32'd0);
    chk("midrst_ram", ram_data_o, 32'd0);
    exp_rom = 32'd0;
    exp_ram = 32'd0;
    @(negedge clk);
    rom_ce_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    txn(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0404, 0, 0,
        32'd0, 32'h9ABC_DEF0, 1'b0, 32'd0);

    // Random transactions.
    for (int k = 0; k < 25; k++) begin
      rce = 1'($urandom_range(1, 0));
      ice = rce ? 1'($urandom_range(1, 0)) : 1'b1;
      txn(rce, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), $urandom, $urandom,
          ice, $urandom, rand_wait(), rand_wait(), $urandom, $urandom, 1'b0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Sits directly downstream of the CPU core's instruction-fetch (rom_*) and load/store (ram_*) ports.
- Serialises both onto one shared single-port memory bus with an ack handshake.
- Data access is served before instruction fetch.
- Raises stallreq_o, which feeds the ctrl unit, until both accesses of the current CPU cycle have completed, then presents the captured read data for one cycle.
- A per-access wait-state watchdog flags a hung slave.

Parameters:
WAIT_MAX, 15, max cycles an access waits for mem_ack_i before it is force-completed (1..255)
CNT_W, 8, width of the wait-state counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
rom_ce_i  in  1  instruction fetch request
rom_addr_i  in  32  fetch address
rom_data_o  out  32  fetched instruction
ram_ce_i  in  1  data access request
ram_we_i  in  1  1=store, 0=load
ram_sel_i  in  4  byte lane enables
ram_addr_i  in  32  data address
ram_data_i  in  32  store data
ram_data_o  out  32  load data, full word (lane extraction done in mem stage)
stallreq_o  out  1  stall request to ctrl
mem_req_o  out  1  bus request, registered
mem_we_o  out  1  bus write enable
mem_sel_o  out  4  bus byte enables
mem_addr_o  out  32  word-aligned bus address
mem_wdata_o  out  32  bus write data
mem_rdata_i  in  32  bus read data, valid with ack
mem_ack_i  in  1  access complete, sampled only while mem_req_o=1
bus_err_o  out  1  one-cycle pulse on watchdog timeout

Behaviour:
- Reset (async, any time including mid-access):
  - State goes to IDLE.
  - mem_req_o, mem_we_o, bus_err_o go to 0; mem_sel_o, mem_addr_o, mem_wdata_o go to 0.
  - Read latches rom_data_o and ram_data_o clear to 0.
  - Wait counter clears.
  - stallreq_o=0 while rst=1.
- States: IDLE, DATA, INST, DONE.
- IDLE:
  - ram_ce_i=1 -> DATA.
  - Else rom_ce_i=1 -> INST.
  - Else stay.
- DATA:
  - mem_req_o=1, mem_we_o=ram_we_i, mem_sel_o=ram_sel_i, mem_wdata_o=ram_data_i.
  - On ack: a load latches mem_rdata_i into ram_data_o; a store latches 0.
  - Then -> INST if rom_ce_i=1, else -> DONE.
- INST:
  - mem_req_o=1, mem_we_o=0, mem_sel_o=4'b1111.
  - On ack: latch mem_rdata_i into rom_data_o, then -> DONE.
- DONE:
  - mem_req_o=0, stallreq_o=0, latches held stable.
  - -> IDLE unconditionally next cycle.
- Bus output timing:
  - Bus outputs are registered and change only on state entry.
  - mem_addr_o = {addr[31:2],2'b00}; the address is never forwarded unaligned.
  - mem_req_o stays high across the DATA->INST transition; the address, we and sel change in that same cycle.
  - Each ack completes exactly one access.
- Stall:
  - stallreq_o = (state!=DONE) && (rom_ce_i || ram_ce_i), combinational.
  - The CPU therefore advances only on the DONE cycle.
  - The CPU holds its request inputs stable while stallreq_o=1; the bridge samples them in DATA/INST.
- Latency:
  - Zero-wait slave, both ports active: IDLE, DATA, INST, DONE = 4 cycles, stall high for 3.
  - Single port active: 3 cycles.
  - Each extra wait cycle adds 1.
- Watchdog:
  - The counter clears on entry to DATA/INST and increments each cycle without ack.
  - When the count reaches WAIT_MAX with no ack, the access is force-completed with latched data 0.
  - bus_err_o pulses high for exactly the transition cycle; the FSM proceeds as if acked.
  - An ack arriving in the same cycle as the timeout wins, and bus_err_o stays 0.
- Ack outside DATA/INST is ignored. Requests that appear in DONE are not served until IDLE.
- Both ce_i low: the block sits idle with stallreq_o=0 and mem_req_o=0.
- Outputs rom_data_o and ram_data_o hold their last value until overwritten or reset.

Test Plan:
- Fetch-only, zero-wait:
  - Stimulus: rom_ce_i=1, rom_addr_i=0x00000004, ack in the first req cycle with rdata 0x3C011234.
  - Required: mem_addr_o=0x00000004, sel=4'hF, we=0; rom_data_o=0x3C011234 in DONE; stallreq_o high for exactly 2 cycles.
- Load plus fetch:
  - Stimulus: ram_ce_i=1, we=0, addr=0x00000103, sel=4'b1000; rom_ce_i=1, addr=0x10; slave acks each with 2 wait cycles, rdata 0xAABBCCDD then 0x24020001.
  - Required: DATA is issued first with mem_addr_o=0x00000100; ram_data_o=0xAABBCCDD; rom_data_o=0x24020001; stall high for 7 cycles.
- Store:
  - Stimulus: ram_we_i=1, sel=4'b0011, data=0x0000BEEF, addr=0x20, rom_ce_i=0.
  - Required: mem_we_o=1, mem_wdata_o=0x0000BEEF, mem_sel_o=4'b0011; ram_data_o=0; FSM goes DATA->DONE directly.
- Watchdog:
  - Stimulus: WAIT_MAX=15, slave never acks a fetch.
  - Required: bus_err_o pulses once after 15 req cycles; rom_data_o=0; DONE reached; stallreq_o drops.
  - Variant: ack on the 15th cycle -> no error, data latched.
- Reset mid-access:
  - Stimulus: assert rst asynchronously (between clock edges) while in INST with mem_req_o=1.
  - Required: mem_req_o, stallreq_o, bus_err_o go to 0 immediately; latches read 0; after release the block serves a fresh request from IDLE.
- Back-to-back:
  - Stimulus: a new fetch request arrives in the DONE cycle.
  - Required: it is ignored that cycle and issued from IDLE the next cycle; an ack in DONE changes no latch.
